adc_conv_ctrl: RTL
==================

Name: adc_conv_ctrl

Overview:
- Conversion sequencer for the 15-comparator flash ADC front end.
- Drives the track/hold switch and the comparator latch strobe, then captures the 15-bit thermometer word and converts it to a 4-bit ones-count.
- Averages 2^AVG_LOG2 conversions and presents the result over a valid/ready handshake to the digital back end.
- Flags bubble errors, i.e. non-monotonic thermometer codes.

Parameters:
- TRACK_CYC, 3: cycles sample_en is held high per conversion (1..15).
- SETTLE_CYC, 2: cycles between hold and latch strobe for comparator settling (1..15).
- AVG_LOG2, 2: log2 of conversions averaged per result (0..4).

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  one-shot request; sampled only in IDLE.
- cont_en  in  1  continuous mode: re-arm automatically after each accepted result.
- therm  in  15  raw comparator outputs; bit 0 is the lowest threshold.
- sample_en  out  1  track/hold switch control; 1 = track.
- latch_en  out  1  comparator latch strobe, one cycle wide.
- busy  out  1  high whenever state is not IDLE.
- dout  out  4  averaged code.
- dout_valid  out  1  result available.
- dout_ready  in  1  consumer accepts the result.
- bubble_err  out  1  sticky: some captured therm word in the current result was not a valid thermometer code.

Behaviour:
- All outputs are Moore decodes of registered state or registers; no combinational path from inputs to outputs.
- Reset (rst low, asynchronous): state=IDLE; sample_en=0, latch_en=0, busy=0, dout=0, dout_valid=0, bubble_err=0; sum and sample counters cleared.
- Reset mid-conversion aborts immediately. No partial result is emitted after release.
- States: IDLE, TRACK, SETTLE, LATCH, ACCUM, OUT.
- IDLE: if start=1 or cont_en=1 at the edge, go to TRACK; clear sum, sample count and bubble_err.
- TRACK: sample_en=1 for exactly TRACK_CYC cycles, then go to SETTLE.
- SETTLE: sample_en=0 for SETTLE_CYC cycles, then go to LATCH.
- LATCH: latch_en=1 for one cycle, then go to ACCUM.
- ACCUM (one cycle):
  - Register therm on this cycle's edge.
  - Add popcount(therm) (0..15) to sum. Sum width is 4+AVG_LOG2 and cannot overflow.
  - Set bubble_err if therm is not of the form 2^k-1 (k=0..15).
  - If sample count is 2^AVG_LOG2-1, load dout = sum_final >> AVG_LOG2 (truncating) and go to OUT; otherwise increment count and go to TRACK.
- Popcount encoding: a single bubble degrades the result by at most one LSB rather than producing a gross error.
- OUT: dout_valid=1; dout and bubble_err are held stable until the handshake.
  - dout_valid=1 and dout_ready=1 at an edge completes the handshake. dout_valid drops at that edge.
  - After the handshake: if cont_en=1, go to TRACK with sum, count and bubble_err cleared; otherwise go to IDLE.
  - dout keeps its last value in IDLE.
- start while busy=1 is ignored and not queued.
- cont_en deasserted mid-sequence: the current result completes and is delivered, then the block goes to IDLE.
- Per-conversion time: TRACK_CYC+SETTLE_CYC+2 cycles. With defaults, dout_valid rises 28 cycles after the edge that samples start.
- dout_ready while in IDLE has no effect.

Test Plan:
- Reset release, start=1 for one cycle, defaults, therm=15'h007F constant:
  - sample_en high for 3 cycles, then latch_en single pulses spaced 7 cycles apart.
  - dout_valid rises at cycle 28 with dout=7, bubble_err=0.
  - dout_ready=1 returns the block to IDLE with busy=0.
- therm sequence 0x0001, 0x0003, 0x0007, 0x000F over the four ACCUM cycles, dout_ready=1 -> sum=10, dout=2 (truncated), bubble_err=0.
- therm=15'h0005 on one conversion, others 0x0007 -> bubble_err=1, dout=(2+3+3+3)>>2=2. bubble_err is cleared at the next start.
- Backpressure: hold dout_ready=0 for 10 cycles in OUT -> dout_valid and dout stable throughout, start pulses ignored. dout_ready=1 for one cycle -> handshake completes and busy=0 next cycle.
- cont_en=1, therm=15'h7FFF -> back-to-back results of dout=15 every 28 cycles plus handshake cycles. Dropping cont_en mid-sequence yields exactly one more result, then IDLE.
- Assert rst low during SETTLE of the 3rd conversion -> all outputs zero asynchronously. After release, the block stays in IDLE with no dout_valid until a new start.

Source files
------------

// File: rtl/adc_conv_ctrl.sv
// Flash-ADC conversion sequencer: track/settle/latch timing, popcount decode of the
// 15-bit thermometer word, 2^AVG_LOG2 averaging and valid/ready result delivery.
module adc_conv_ctrl #(
  parameter int TRACK_CYC  = 3,
  parameter int SETTLE_CYC = 2,
  parameter int AVG_LOG2   = 2
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        start_i,
  input  logic        cont_en_i,
  input  logic [14:0] therm_i,
  output logic        sample_en_o,
  output logic        latch_en_o,
  output logic        busy_o,
  output logic [3:0]  dout_o,
  output logic        dout_valid_o,
  input  logic        dout_ready_i,
  output logic        bubble_err_o
);

  localparam int SW = 4 + AVG_LOG2;
  localparam logic [4:0] LAST_CNT   = 5'((1 << AVG_LOG2) - 1);
  localparam logic [3:0] TRACK_LAST  = 4'(TRACK_CYC - 1);
  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE_CYC - 1);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    TRACK  = 3'd1,
    SETTLE = 3'd2,
    LATCH  = 3'd3,
    ACCUM  = 3'd4,
    OUT    = 3'd5
  } state_e;

  state_e          state_q;
  logic [3:0]      cyc_q;
  logic [4:0]      cnt_q;
  logic [SW-1:0]   sum_q;
  logic [3:0]      dout_q;
  logic            sample_en_q;
  logic            latch_en_q;
  logic            busy_q;
  logic            dout_valid_q;
  logic            bubble_err_q;

  logic [3:0]      pop_d;
  logic [SW-1:0]   sum_d;
  logic [15:0]     therm_ext;
  logic            therm_bad;

  // Ones-count rather than priority encode: a single bubble costs at most one LSB.
  always_comb begin
    pop_d = 4'd0;
    for (int i = 0; i < 15; i++) begin
      pop_d = pop_d + {3'd0, therm_i[i]};
    end
  end

  // A valid thermometer code is 2^k-1, i.e. t & (t+1) == 0.
  assign therm_ext = {1'b0, therm_i};
  assign therm_bad = |(therm_ext & (therm_ext + 16'd1));
  assign sum_d     = sum_q + SW'(pop_d);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      cyc_q        <= 4'd0;
      cnt_q        <= 5'd0;
      sum_q        <= '0;
      dout_q       <= 4'd0;
      sample_en_q  <= 1'b0;
      latch_en_q   <= 1'b0;
      busy_q       <= 1'b0;
      dout_valid_q <= 1'b0;
      bubble_err_q <= 1'b0;
    end else begin
      latch_en_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i || cont_en_i) begin
            state_q      <= TRACK;
            cyc_q        <= 4'd0;
            cnt_q        <= 5'd0;
            sum_q        <= '0;
            bubble_err_q <= 1'b0;
            sample_en_q  <= 1'b1;
            busy_q       <= 1'b1;
          end
        end
        TRACK: begin
          if (cyc_q == TRACK_LAST) begin
            state_q     <= SETTLE;
            cyc_q       <= 4'd0;
            sample_en_q <= 1'b0;
          end else begin
            cyc_q <= cyc_q + 4'd1;
          end
        end
        SETTLE: begin
          if (cyc_q == SETTLE_LAST) begin
            state_q    <= LATCH;
            cyc_q      <= 4'd0;
            latch_en_q <= 1'b1;
          end else begin
            cyc_q <= cyc_q + 4'd1;
          end
        end
        LATCH: begin
          state_q <= ACCUM;
        end
        ACCUM: begin
          sum_q <= sum_d;
          if (therm_bad) begin
            bubble_err_q <= 1'b1;
          end
          if (cnt_q == LAST_CNT) begin
            dout_q       <= 4'(sum_d >> AVG_LOG2);
            dout_valid_q <= 1'b1;
            state_q      <= OUT;
          end else begin
            cnt_q       <= cnt_q + 5'd1;
            cyc_q       <= 4'd0;
            sample_en_q <= 1'b1;
            state_q     <= TRACK;
          end
        end
        OUT: begin
          if (dout_ready_i) begin
            dout_valid_q <= 1'b0;
            if (cont_en_i) begin
              state_q      <= TRACK;
              cyc_q        <= 4'd0;
              cnt_q        <= 5'd0;
              sum_q        <= '0;
              bubble_err_q <= 1'b0;
              sample_en_q  <= 1'b1;
            end else begin
              state_q <= IDLE;
              busy_q  <= 1'b0;
            end
          end
        end
        default: begin
          state_q      <= IDLE;
          busy_q       <= 1'b0;
          sample_en_q  <= 1'b0;
          dout_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign sample_en_o  = sample_en_q;
  assign latch_en_o   = latch_en_q;
  assign busy_o       = busy_q;
  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign bubble_err_o = bubble_err_q;

endmodule
